// File: rtl/line_clear_engine.sv
// ---------------------------------------------------------------------------
// line_clear_engine
//
// Removes every full row from a ROWS x COLS board in one multi-cycle pass and
// compacts the surviving rows toward the bottom. The rows left empty at the
// top are zero-filled. It then checks the spawn region for a collision and
// adds the cleared count to a saturating running total.
//
// Control is a start/done handshake driven by the game FSM. Row r of a board
// vector occupies bits [r*COLS+COLS-1 : r*COLS]. Row 0 is the top (spawn)
// row and row ROWS-1 is the bottom row.
//
// Ports
//   clka          in   1          system clock, all state on posedge
//   restart_n     in   1          asynchronous active-low reset
//   start         in   1          request a clear pass (honoured in IDLE only)
//   new_game      in   1          synchronous soft clear, beats start
//   board_in      in   ROWS*COLS  board to process, captured on the start edge
//   spawn_mask    in   ROWS*COLS  next-piece cells, captured with board_in
//   busy          out  1          pass in flight (COMPACT or CHECK)
//   done          out  1          one-cycle pulse, results valid from here
//   board_out     out  ROWS*COLS  compacted board, held until next done
//   lines_cleared out  LC_W       full rows removed by the last pass
//   total_lines   out  SCORE_W    saturating sum of lines_cleared
//   game_over     out  1          compacted board overlaps spawn_mask
// ---------------------------------------------------------------------------
module line_clear_engine #(
    parameter int ROWS    = 8,
    parameter int COLS    = 4,
    parameter int SCORE_W = 16
) (
    input  logic                         clka,
    input  logic                         restart_n,
    input  logic                         start,
    input  logic                         new_game,
    input  logic [ROWS*COLS-1:0]         board_in,
    input  logic [ROWS*COLS-1:0]         spawn_mask,
    output logic                         busy,
    output logic                         done,
    output logic [ROWS*COLS-1:0]         board_out,
    output logic [$clog2(ROWS+1)-1:0]    lines_cleared,
    output logic [SCORE_W-1:0]           total_lines,
    output logic                         game_over
);

    localparam int LC_W  = $clog2(ROWS+1);
    localparam int BW    = ROWS * COLS;
    localparam int RD_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SUM_W = (SCORE_W + 1 > LC_W) ? SCORE_W + 1 : LC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPACT = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_busy;

    logic [BW-1:0]       r_src;
    logic [BW-1:0]       r_msk;
    logic [BW-1:0]       r_work;
    logic [RD_W-1:0]     r_rd;
    logic [RD_W-1:0]     r_wr;
    logic [LC_W-1:0]     r_count;

    logic [BW-1:0]       r_board_out;
    logic [LC_W-1:0]     r_lines;
    logic [SCORE_W-1:0]  r_total;
    logic                r_game_over;
    logic                r_done;

    logic [COLS-1:0]     w_src_row;
    logic                w_row_full;

    // Add at a wider width first, then clamp to the all-ones maximum.
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] acc,
        input logic [LC_W-1:0]    inc
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(inc);
        if (sum > SUM_W'({SCORE_W{1'b1}}))
            return {SCORE_W{1'b1}};
        else
            return sum[SCORE_W-1:0];
    endfunction

    assign w_src_row  = r_src[r_rd*COLS +: COLS];
    assign w_row_full = &w_src_row;

    // ---------------- state register ----------------
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // ---------------- next state / control ----------------
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_COMPACT;
                end
            end
            S_COMPACT: begin
                w_busy = 1'b1;
                // rd counts down from ROWS-1; row 0 is the last one visited
                if (r_rd == '0)
                    w_next = S_CHECK;
            end
            S_CHECK: begin
                w_busy = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // A soft clear overrides everything, including a same-cycle start.
        if (new_game) begin
            w_next   = S_IDLE;
            w_accept = 1'b0;
        end
    end

    // ---------------- datapath and result registers ----------------
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            r_src       <= '0;
            r_msk       <= '0;
            r_work      <= '0;
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            r_board_out <= '0;
            r_lines     <= '0;
            r_total     <= '0;
            r_game_over <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (new_game) begin
                r_board_out <= '0;
                r_lines     <= '0;
                r_total     <= '0;
                r_game_over <= 1'b0;
                r_work      <= '0;
                r_count     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_src   <= board_in;
                            r_msk   <= spawn_mask;
                            // Starting from an empty work board means rows
                            // above the final write pointer are already zero.
                            r_work  <= '0;
                            r_rd    <= RD_W'(ROWS-1);
                            r_wr    <= RD_W'(ROWS-1);
                            r_count <= '0;
                        end
                    end
                    S_COMPACT: begin
                        if (w_row_full) begin
                            r_count <= r_count + 1'b1;
                        end else begin
                            r_work[r_wr*COLS +: COLS] <= w_src_row;
                            r_wr <= r_wr - 1'b1;
                        end
                        r_rd <= r_rd - 1'b1;
                    end
                    S_CHECK: begin
                        r_board_out <= r_work;
                        r_lines     <= r_count;
                        r_game_over <= |(r_work & r_msk);
                        r_total     <= sat_add(r_total, r_count);
                        r_done      <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign busy          = w_busy;
    assign done          = r_done;
    assign board_out     = r_board_out;
    assign lines_cleared = r_lines;
    assign total_lines   = r_total;
    assign game_over     = r_game_over;

endmodule

// File: tb/tb_line_clear_engine.sv
// ---------------------------------------------------------------------------
// tb_line_clear_engine
//
// Directed and randomised passes through line_clear_engine (ROWS=8, COLS=4,
// SCORE_W=4). Expected results come from a row-list reference model: keep
// the non-full rows in top-to-bottom order and stack them against the bottom.
// ---------------------------------------------------------------------------
module tb_line_clear_engine;

    logic        clka;
    logic        restart_n;
    logic        start;
    logic        new_game;
    logic [31:0] board_in;
    logic [31:0] spawn_mask;
    logic        busy;
    logic        done;
    logic [31:0] board_out;
    logic [3:0]  lines_cleared;
    logic [3:0]  total_lines;
    logic        game_over;

    int n_cmp;
    int n_fail;
    int exp_total;

    line_clear_engine #(
        .ROWS    (8),
        .COLS    (4),
        .SCORE_W (4)
    ) dut (
        .clka          (clka),
        .restart_n     (restart_n),
        .start         (start),
        .new_game      (new_game),
        .board_in      (board_in),
        .spawn_mask    (spawn_mask),
        .busy          (busy),
        .done          (done),
        .board_out     (board_out),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines),
        .game_over     (game_over)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: surviving rows keep their top-to-bottom order and sit at
    // the bottom of the board; everything above them is empty.
    function automatic void model(input logic [31:0] b, output logic [31:0] ob, output int nl);
        logic [3:0] kept[$];
        logic [3:0] row;
        ob = '0;
        for (int r = 0; r < 8; r++) begin
            row = b[r*4 +: 4];
            if (row != 4'hF) kept.push_back(row);
        end
        nl = 8 - kept.size();
        for (int i = 0; i < kept.size(); i++)
            ob[(nl + i)*4 +: 4] = kept[i];
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  64'(busy),          64'(0));
        check({tag, "_done"},  64'(done),          64'(0));
        check({tag, "_board"}, 64'(board_out),     64'(0));
        check({tag, "_lines"}, 64'(lines_cleared), 64'(0));
        check({tag, "_total"}, 64'(total_lines),   64'(0));
        check({tag, "_go"},    64'(game_over),     64'(0));
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int n_done;
        n_done = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clka);
            if (done) n_done++;
        end
        check({tag, "_no_done"}, 64'(n_done), 64'(0));
    endtask

    task automatic run_pass(input string tag, input logic [31:0] b, input logic [31:0] m,
                            input int pulse_at);
        logic [31:0] exp_b;
        int          exp_l;
        int          lat;
        int          busy_cnt;
        bit          seen;
        model(b, exp_b, exp_l);
        exp_total = (exp_total + exp_l > 15) ? 15 : exp_total + exp_l;

        @(negedge clka);
        board_in   = b;
        spawn_mask = m;
        start      = 1'b1;
        @(posedge clka);
        seen     = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clka);
            start      = (k == pulse_at);
            // Inputs wander after capture; the pass in flight must ignore them.
            board_in   = $urandom;
            spawn_mask = $urandom;
            if (done) begin
                seen = 1'b1;
                lat  = k - 1;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'(1));
        check({tag, "_latency"},   64'(lat), 64'(9));
        check({tag, "_busy_cyc"},  64'(busy_cnt), 64'(9));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        check({tag, "_board"},     64'(board_out), 64'(exp_b));
        check({tag, "_lines"},     64'(lines_cleared), 64'(exp_l));
        check({tag, "_go"},        64'(game_over), 64'(|(exp_b & m)));
        check({tag, "_total"},     64'(total_lines), 64'(exp_total));
        @(negedge clka);
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
        check({tag, "_board_hold"}, 64'(board_out), 64'(exp_b));
        if (pulse_at > 0) expect_no_done({tag, "_ignored_start"}, 12);
    endtask

    initial begin
        logic [31:0] rb;
        logic [31:0] rm;
        n_cmp      = 0;
        n_fail     = 0;
        exp_total  = 0;
        restart_n  = 1'b0;
        start      = 1'b0;
        new_game   = 1'b0;
        board_in   = '0;
        spawn_mask = '0;

        #12;
        check_outputs_zero("reset");
        @(negedge clka);
        restart_n = 1'b1;

        run_pass("adj_double", 32'hFF21_0000, 32'h0000_0002, 0);
        run_pass("triple",     32'hF1F2_F300, 32'h0000_0000, 0);
        run_pass("collide",    32'h0000_0012, 32'h0000_0002, 0);
        run_pass("late_start", 32'hF0F0_00F1, 32'h0000_0010, 4);

        // new_game with a simultaneous start: clear wins, no pass begins.
        @(negedge clka);
        new_game = 1'b1;
        start    = 1'b1;
        @(negedge clka);
        new_game = 1'b0;
        start    = 1'b0;
        exp_total = 0;
        check_outputs_zero("new_game");

        run_pass("full1", 32'hFFFF_FFFF, 32'h0000_000F, 0);
        run_pass("full2", 32'hFFFF_FFFF, 32'h0000_000F, 0);

        @(negedge clka);
        new_game = 1'b1;
        @(negedge clka);
        new_game = 1'b0;
        exp_total = 0;
        check_outputs_zero("new_game2");

        for (int p = 0; p < 12; p++) begin
            rb = '0;
            for (int r = 0; r < 8; r++)
                rb[r*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            rm = $urandom & 32'h0000_00FF;
            run_pass($sformatf("rand%0d", p), rb, rm, 0);
        end

        // new_game in the middle of a pass: abort silently.
        @(negedge clka);
        board_in = 32'hF000_0000;
        start    = 1'b1;
        @(posedge clka);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clka);
            start    = 1'b0;
            new_game = (k == 3);
        end
        @(negedge clka);
        new_game  = 1'b0;
        exp_total = 0;
        check("ng_mid_busy",  64'(busy), 64'(0));
        check("ng_mid_total", 64'(total_lines), 64'(0));
        expect_no_done("ng_mid", 12);

        // Build up a nonzero total, then reset during the 4th COMPACT cycle.
        run_pass("pre_rst", 32'h00F0_FF00, 32'h0000_0001, 0);
        @(negedge clka);
        board_in = 32'hFF00_0000;
        start    = 1'b1;
        @(posedge clka);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clka);
            start = 1'b0;
        end
        restart_n = 1'b0;
        #1;
        exp_total = 0;
        check_outputs_zero("rst_mid");
        @(negedge clka);
        restart_n = 1'b1;
        expect_no_done("rst_mid", 12);
        run_pass("post_rst", 32'h0F0F_F0F0, 32'h0000_00F0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
- Parametrised successor to the fixed 8x4 clear/redraw logic.
- Removes every full row from a ROWS x COLS board in one multi-cycle operation, with any number of full rows, adjacent or not; compacts the remaining rows downward and zero-fills the top.
- Then checks the spawn region for game over and accumulates a saturating lines-cleared total.
- Sits between the landing/merge logic and the GEN phase; the game FSM controls it through a start/done handshake.

Parameters:
- ROWS, 8, board height; row 0 = top/spawn row, row ROWS-1 = bottom.
- COLS, 4, board width; row r occupies bits [r*COLS+COLS-1 : r*COLS].
- SCORE_W, 16, width of the total_lines accumulator.
- Derived, not overridable: LC_W = $clog2(ROWS+1).

Ports:
- clka  input  1  single system clock; all state updates on posedge.
- restart_n  input  1  asynchronous active-low reset.
- start  input  1  request one clear pass; sampled in IDLE only.
- new_game  input  1  synchronous soft clear.
- board_in  input  ROWS*COLS  board to process; captured on the start cycle.
- spawn_mask  input  ROWS*COLS  cells the next piece will occupy; captured with board_in.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result outputs valid from this cycle.
- board_out  output  ROWS*COLS  compacted board; held until the next done.
- lines_cleared  output  LC_W  full rows removed by the last pass.
- total_lines  output  SCORE_W  saturating sum of lines_cleared since reset or new_game.
- game_over  output  1  |(board_out & spawn_mask) for the last pass.

Behaviour:
- Reset (restart_n low, asynchronous): state IDLE; busy=0, done=0, board_out=0, lines_cleared=0, total_lines=0, game_over=0; internal registers cleared.
- States: IDLE, COMPACT, CHECK.
- IDLE:
  - Sampling edge with start=1 and new_game=0: snapshot board_in into src and spawn_mask into msk.
  - Work board = 0, rd = wr = ROWS-1, count = 0, go to COMPACT.
  - busy=1 from the next cycle.
- COMPACT: one source row per cycle, exactly ROWS cycles.
  - If src row rd is all ones: count++.
  - Otherwise: work row wr <= src row rd, then wr--.
  - rd-- every cycle.
  - After processing rd=0, go to CHECK.
  - Rows above the final wr stay 0 because work starts at 0; no separate fill step.
- CHECK, one cycle:
  - board_out <= work; lines_cleared <= count; game_over <= |(work & msk).
  - total_lines <= min(total_lines + count, 2^SCORE_W-1).
  - done=1 for this one cycle, busy=0, return to IDLE.
- Latency: done asserts ROWS+1 clocks after the start sampling edge (9 for ROWS=8). Throughput is one pass per ROWS+2 cycles.
- start while busy: ignored, no queuing. start held high in IDLE: a new pass begins the cycle after done.
- A partially filled row is never cleared. A pass with no full rows gives board_out = board_in and lines_cleared = 0.
- game_over is computed on the compacted board, so a clear can rescue a spawn collision.
- new_game (any state):
  - Next edge: state IDLE; board_out, lines_cleared, total_lines, game_over = 0; busy = 0; no done pulse.
  - Takes priority over start in the same cycle.
- restart_n asserted mid-COMPACT: immediate abort to reset values; no done.
- board_in and spawn_mask changes after capture have no effect on the pass in flight.
- Accumulator addition is done at SCORE_W+1 bits, then clamped.

Test Plan (ROWS=8, COLS=4, SCORE_W=4; row 7 = bits 31:28):
- Adjacent double clear: board_in=0xFF21_0000, spawn_mask=0x0000_0002, start -> done exactly 9 cycles later; board_out=0x2100_0000, lines_cleared=2, game_over=0, total_lines=2.
- Non-adjacent triple clear: board_in=0xF1F2_F300 -> board_out=0x1230_0000, lines_cleared=3; busy high for 9 cycles.
- No clear, spawn collision: board_in=0x0000_0012, spawn_mask=0x0000_0002 -> board_out=0x0000_0012, lines_cleared=0, game_over=1.
- Full board, then saturation:
  - First pass, board_in=0xFFFF_FFFF -> board_out=0, lines_cleared=8, total_lines=8.
  - Second identical pass -> total_lines=15 (saturated).
  - new_game -> total_lines=0.
- start pulsed 3 cycles after an accepted start -> ignored; exactly one done.
- restart_n low during the 4th COMPACT cycle -> all outputs 0 immediately, no done; a fresh start after release completes normally.
